ff_driver_bank: RTL

Multi-channel, parametrised force-format pin driver for the ASIC tester pattern path. One shared tester-cycle counter drives CH independent channels. Each channel has its own leading/trailing edge placement and a 3-bit force format, with NRZ, DNRZ_L, RZ, R1, RC and SBC supported. It sits between the pattern memory sequencer (supplies D/FF once per tester cycle) and the DUT pin drivers.

---
 rtl/ff_driver_bank.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ff_driver_bank.sv
// Multi-channel force-format pin driver: one shared tester-cycle counter,
// per-channel leading/trailing edge placement and NRZ/DNRZ_L/RZ/R1/RC/SBC formats.
module ff_driver_bank #(
  parameter int unsigned CH = 8,
  parameter int unsigned CW = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [CW-1:0]      CYCLE_LENGTH,
  input  logic [CH*CW-1:0]   LEADING_EDGE,
  input  logic [CH*CW-1:0]   TRAILING_EDGE,
  input  logic [CH-1:0]      D,
  input  logic [3*CH-1:0]    FF,
  output logic [CH-1:0]      Q,
  output logic               CYC_START
);

  localparam int unsigned FW = 3;

  typedef enum logic [FW-1:0] {
    FMT_NRZ    = 3'd0,
    FMT_DNRZ_L = 3'd1,
    FMT_RZ     = 3'd2,
    FMT_R1     = 3'd3,
    FMT_RC     = 3'd4,
    FMT_SBC    = 3'd5,
    FMT_RSV6   = 3'd6,
    FMT_RSV7   = 3'd7
  } fmt_e;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CH-1:0]    q_q, q_d;
  logic [CH-1:0]    dcur_q, dcur_d;
  logic [FW*CH-1:0] ffcur_q, ffcur_d;
  logic             cyc_start_q, cyc_start_d;

  logic [CW-1:0]    clen_c;
  logic             start_c;

  // Effective cycle length: 0 behaves like 1 for edge range qualification.
  assign clen_c  = (CYCLE_LENGTH == '0) ? CW'(1) : CYCLE_LENGTH;
  assign start_c = EN && (cnt_q == CW'(1));

  // Shared counter, captured cycle data and start strobe.
  always_comb begin
    cnt_d       = cnt_q;
    dcur_d      = dcur_q;
    ffcur_d     = ffcur_q;
    cyc_start_d = 1'b0;
    if (EN) begin
      cnt_d = (cnt_q >= CYCLE_LENGTH) ? CW'(1) : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end
    if (start_c) begin
      dcur_d      = D;
      ffcur_d     = FF;
      cyc_start_d = 1'b1;
    end
  end

  // Per-channel pin value; an event only counts if the format gives it an action.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < CH; i++) begin
      logic [CW-1:0] le;
      logic [CW-1:0] te;
      logic          v;
      fmt_e          f;
      logic          lead_hit;
      logic          trail_hit;
      logic          st_act;
      logic          ld_act;
      logic          tr_act;
      le        = LEADING_EDGE[i*CW +: CW];
      te        = TRAILING_EDGE[i*CW +: CW];
      v         = start_c ? D[i] : dcur_q[i];
      f         = fmt_e'(start_c ? FF[FW*i +: FW] : ffcur_q[FW*i +: FW]);
      lead_hit  = EN && (le != '0) && (le <= clen_c) && (cnt_q == le);
      trail_hit = EN && (te != '0) && (te <= clen_c) && (cnt_q == te);
      st_act    = start_c && (f inside {FMT_NRZ, FMT_SBC, FMT_RSV6, FMT_RSV7});
      ld_act    = lead_hit && (f inside {FMT_DNRZ_L, FMT_RZ, FMT_R1, FMT_RC, FMT_SBC});
      tr_act    = trail_hit && (f inside {FMT_RZ, FMT_R1, FMT_RC, FMT_SBC});
      if (tr_act) begin
        case (f)
          FMT_RZ:  q_d[i] = 1'b0;
          FMT_R1:  q_d[i] = 1'b1;
          default: q_d[i] = ~v;
        endcase
      end else if (ld_act) begin
        q_d[i] = v;
      end else if (st_act) begin
        case (f)
          FMT_NRZ: q_d[i] = v;
          FMT_SBC: q_d[i] = ~v;
          default: q_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= CW'(1);
      q_q         <= '0;
      dcur_q      <= '0;
      ffcur_q     <= '0;
      cyc_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      dcur_q      <= dcur_d;
      ffcur_q     <= ffcur_d;
      cyc_start_q <= cyc_start_d;
    end
  end

  assign Q         = q_q;
  assign CYC_START = cyc_start_q;

endmodule
